ram_slot_scheduler: RTL and testbench
=====================================

# ram_slot_scheduler

Time-slot scheduler for the single shared RAM port of the Mac Plus/SE core. It divides time into fixed 8-clock memory slots and assigns each slot to one owner: video fetch, sound fetch, CPU, or refresh. It produces the bus-ownership, load and cycle-complete strobes consumed by the data controller and video shifter, plus the CPU DTACK handshake. It sits between the CPU/address decode and the RAM controller.

## Interface
- REFRESH_INTERVAL, 64: slots between refresh requests.
- REFRESH_MAX_WAIT, 4: slots a pending refresh may wait before it pre-empts a CPU slot.
- clk  in  1  16 MHz system clock
- _systemReset  in  1  reset, asynchronous, active-low
- _hblank  in  1  low during horizontal blank
- _vblank  in  1  low during vertical blank
- cpu_req  in  1  CPU RAM/ROM access requested (AS low and memory selected), level
- cpu_rw  in  1  1 = read, 0 = write; valid while cpu_req=1
- videoBusControl  out  1  current slot owned by video or sound
- cpuBusControl  out  1  current slot owned by CPU
- loadPixels  out  1  current slot is a video fetch (level, whole slot)
- loadSound  out  1  current slot is a sound fetch (level, whole slot)
- refresh  out  1  current slot is a refresh slot (level, whole slot)
- cycleReady  out  1  one-clock pulse at the last phase of any owned slot
- ram_oe  out  1  RAM output enable
- ram_we  out  1  RAM write enable
- cpu_dtack  out  1  CPU data acknowledge, active high

## Operation
- phase: 3-bit counter, +1 every clk, wraps 7→0; slot boundary at phase 0. slot_par toggles at every phase 7→0 transition.
- Owner is decided once at phase 0 and held for phases 0..7. Priority at phase 0:
  1. Even slot (slot_par=0) with _hblank=1 and _vblank=1: video.
  2. Even slot with snd_pending=1 and _hblank=0: sound. snd_pending is cleared at that decision.
  3. Refresh, if ref_wait ≥ REFRESH_MAX_WAIT: refresh, pre-empting CPU.
  4. CPU, if cpu_req=1 and served=0.
  5. Refresh, if ref_pending=1.
  6. Otherwise idle: all level outputs 0, no cycleReady.
- snd_pending is set on the clock after a 1→0 edge of _hblank, at most one per line. A second edge arriving while it is still set is absorbed.
- Refresh timer counts slots. Every REFRESH_INTERVAL slots it sets ref_pending. ref_wait counts slots while ref_pending=1. Both clear when a refresh slot is granted. A new interval expiry while a refresh is still pending is absorbed.
- CPU handshake:
  - served is set when a CPU slot is granted.
  - cpu_dtack rises at phase 6 of the CPU slot and stays high until cpu_req=0.
  - served and cpu_dtack clear on the clock after cpu_req=0.
  - Result: exactly one slot per request strobe.
  - A cpu_req that rises mid-slot waits for the next phase 0 at which it wins priority.
- ram_oe: video, sound, or CPU read slot, phases 1..7.
- ram_we: CPU write slot (cpu_rw=0 latched at phase 0), phases 2..5.
- Refresh slot: ram_oe=0, ram_we=0.

## Timing
- Reset (asynchronous, _systemReset=0):
  - phase=0, slot_par=0.
  - All pending flags, counters, served cleared.
  - All outputs 0.
  - First decision at the first phase 0 after release.
- Owner-level outputs are registered: they change on the clk edge entering phase 0.
- cycleReady is high for exactly the clk where phase=7 in an owned (non-idle) slot, refresh included.
- CPU latency from cpu_req sampled at phase 0 to cpu_dtack: 6 clk. Worst case during active display: +8 clk for one video slot.
- Reset mid-slot aborts the slot with no cycleReady. cpu_dtack drops immediately.
- Video never waits; refresh may delay a CPU slot by at most one slot.

## Test plan
- Active display, no CPU: owners alternate video/idle every 8 clk. loadPixels high 8 clk out of every 16. cycleReady pulses only at phase 7 of video slots.
- Active display, cpu_req held from reset, read: CPU is granted odd slots only. cpu_dtack rises at phase 6. Dropping cpu_req at clk 20 clears cpu_dtack at clk 21. Re-asserting gets the next odd slot.
- CPU write with cpu_rw=0: ram_we high for exactly phases 2..5 (4 clk). ram_oe stays 0.
- _hblank falls: the next even slot during hblank has loadSound=1 and ram_oe=1, exactly once per line. A following even slot in the same hblank is CPU or idle.
- cpu_req held permanently with REFRESH_INTERVAL=64:
  - Refresh is starved only during vblank+hblank CPU saturation.
  - After 4 pending slots, refresh takes a CPU slot: refresh=1, cycleReady pulse, no dtack.
- Assert _systemReset at phase 4 of a CPU slot: all outputs 0 the same cycle. After release, the first owned slot starts at phase 0 with no stale dtack.

Source files
------------

// File: rtl/ram_slot_scheduler.sv
// rtl/ram_slot_scheduler.sv - 8-clock shared RAM slot arbiter for video, sound, CPU and refresh
// Owner is chosen on the edge entering phase 0 and all strobes are registered.
module ram_slot_scheduler #(
  parameter int REFRESH_INTERVAL = 64,
  parameter int REFRESH_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic _systemReset,
  input  logic _hblank,
  input  logic _vblank,
  input  logic cpu_req,
  input  logic cpu_rw,
  output logic videoBusControl,
  output logic cpuBusControl,
  output logic loadPixels,
  output logic loadSound,
  output logic refresh,
  output logic cycleReady,
  output logic ram_oe,
  output logic ram_we,
  output logic cpu_dtack
);

  localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int WW = $clog2(REFRESH_MAX_WAIT + 2);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_INTERVAL - 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(REFRESH_MAX_WAIT);

  typedef enum logic [2:0] {
    OWN_IDLE,
    OWN_VIDEO,
    OWN_SOUND,
    OWN_CPU,
    OWN_REFRESH
  } owner_t;

  logic [2:0]    phase;
  logic [2:0]    phase_n;
  logic          slot_par;
  logic          boundary;
  owner_t        owner;
  owner_t        next_owner;
  owner_t        owner_n;
  logic          cpu_write;
  logic          cpu_write_n;
  logic          snd_pending;
  logic          hblank_d;
  logic          ref_pending;
  logic [WW-1:0] ref_wait;
  logic [TW-1:0] ref_timer;
  logic          served;

  // slot_par still holds the parity of the slot being left, so 1 means an even slot is next
  always_comb begin
    phase_n  = phase + 3'd1;
    boundary = (phase == 3'd7);
    next_owner = OWN_IDLE;
    if (slot_par && _hblank && _vblank)
      next_owner = OWN_VIDEO;
    else if (slot_par && snd_pending && !_hblank)
      next_owner = OWN_SOUND;
    else if (ref_pending && (ref_wait >= WAIT_LIMIT))
      next_owner = OWN_REFRESH;
    else if (cpu_req && !served)
      next_owner = OWN_CPU;
    else if (ref_pending)
      next_owner = OWN_REFRESH;
    owner_n     = boundary ? next_owner : owner;
    cpu_write_n = boundary ? ~cpu_rw : cpu_write;
  end

  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset) begin
      phase           <= 3'd0;
      slot_par        <= 1'b0;
      owner           <= OWN_IDLE;
      cpu_write       <= 1'b0;
      snd_pending     <= 1'b0;
      hblank_d        <= 1'b0;
      ref_pending     <= 1'b0;
      ref_wait        <= '0;
      ref_timer       <= '0;
      served          <= 1'b0;
      videoBusControl <= 1'b0;
      cpuBusControl   <= 1'b0;
      loadPixels      <= 1'b0;
      loadSound       <= 1'b0;
      refresh         <= 1'b0;
      cycleReady      <= 1'b0;
      ram_oe          <= 1'b0;
      ram_we          <= 1'b0;
      cpu_dtack       <= 1'b0;
    end else begin
      phase    <= phase_n;
      hblank_d <= _hblank;

      if (boundary) begin
        slot_par  <= ~slot_par;
        owner     <= next_owner;
        cpu_write <= ~cpu_rw;
        ref_timer <= (ref_timer == TIMER_LAST) ? '0 : ref_timer + 1'b1;
        if (next_owner == OWN_REFRESH) begin
          ref_pending <= 1'b0;
          ref_wait    <= '0;
        end else if (ref_pending && (ref_wait < WAIT_LIMIT)) begin
          ref_wait <= ref_wait + 1'b1;
        end
        // an expiry while a refresh is already pending just keeps it pending
        if (ref_timer == TIMER_LAST)
          ref_pending <= 1'b1;
      end

      if (hblank_d && !_hblank)
        snd_pending <= 1'b1;
      else if (boundary && (next_owner == OWN_SOUND))
        snd_pending <= 1'b0;

      // served holds off a second grant until the CPU ends its bus cycle
      if (!cpu_req)
        served <= 1'b0;
      else if (boundary && (next_owner == OWN_CPU))
        served <= 1'b1;

      if (!cpu_req)
        cpu_dtack <= 1'b0;
      else if ((owner_n == OWN_CPU) && (phase_n == 3'd6))
        cpu_dtack <= 1'b1;

      videoBusControl <= (owner_n == OWN_VIDEO) || (owner_n == OWN_SOUND);
      cpuBusControl   <= (owner_n == OWN_CPU);
      loadPixels      <= (owner_n == OWN_VIDEO);
      loadSound       <= (owner_n == OWN_SOUND);
      refresh         <= (owner_n == OWN_REFRESH);
      cycleReady      <= (owner_n != OWN_IDLE) && (phase_n == 3'd7);
      ram_oe          <= (phase_n != 3'd0) &&
                         ((owner_n == OWN_VIDEO) || (owner_n == OWN_SOUND) ||
                          ((owner_n == OWN_CPU) && !cpu_write_n));
      ram_we          <= (owner_n == OWN_CPU) && cpu_write_n &&
                         (phase_n >= 3'd2) && (phase_n <= 3'd5);
    end
  end

endmodule

// File: tb/tb_ram_slot_scheduler.sv
// tb/tb_ram_slot_scheduler.sv - slot table with owner scoreboard plus CPU, reset and refresh sequences
module tb_ram_slot_scheduler;

  typedef enum int {O_IDLE, O_VIDEO, O_SOUND, O_CPU, O_REF} own_e;
  typedef struct {
    logic hb;
    logic vb;
    logic req;
    logic rd;
    own_e own;
  } row_t;
  typedef struct {
    own_e own;
    logic rd;
  } exp_t;

  localparam int NROWS = 21;

  logic clk = 1'b0;
  logic _systemReset = 1'b0;
  logic _hblank = 1'b1;
  logic _vblank = 1'b1;
  logic cpu_req = 1'b0;
  logic cpu_rw = 1'b1;
  logic videoBusControl, cpuBusControl, loadPixels, loadSound, refresh;
  logic cycleReady, ram_oe, ram_we, cpu_dtack;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  row_t rows [NROWS];
  exp_t sb [$];
  exp_t cur, e;
  int ref_slot, nref, ncpu;
  logic after_ref_cpu;

  ram_slot_scheduler #(.REFRESH_INTERVAL(64), .REFRESH_MAX_WAIT(4)) dut (
    .clk(clk),
    ._systemReset(_systemReset),
    ._hblank(_hblank),
    ._vblank(_vblank),
    .cpu_req(cpu_req),
    .cpu_rw(cpu_rw),
    .videoBusControl(videoBusControl),
    .cpuBusControl(cpuBusControl),
    .loadPixels(loadPixels),
    .loadSound(loadSound),
    .refresh(refresh),
    .cycleReady(cycleReady),
    .ram_oe(ram_oe),
    .ram_we(ram_we),
    .cpu_dtack(cpu_dtack)
  );

  always #5 clk = ~clk;

  // {videoBusControl, cpuBusControl, loadPixels, loadSound, refresh, cycleReady, ram_oe, ram_we, cpu_dtack}
  function automatic logic [8:0] outv();
    return {videoBusControl, cpuBusControl, loadPixels, loadSound, refresh,
            cycleReady, ram_oe, ram_we, cpu_dtack};
  endfunction

  function automatic logic [8:0] expv(own_e o, logic rd, int ph);
    logic [8:0] v;
    v = '0;
    v[3] = (o != O_IDLE) && (ph == 7);
    case (o)
      O_VIDEO: begin v[8] = 1'b1; v[6] = 1'b1; v[2] = (ph != 0); end
      O_SOUND: begin v[8] = 1'b1; v[5] = 1'b1; v[2] = (ph != 0); end
      O_CPU: begin
        v[7] = 1'b1;
        v[2] = rd && (ph != 0);
        v[1] = !rd && (ph >= 2) && (ph <= 5);
        v[0] = (ph == 6);
      end
      O_REF: v[4] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(int target);
    while (cyc < target) next();
  endtask

  task automatic do_reset();
    _systemReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(outv()), 32'd0);
    @(negedge clk);
    _systemReset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rows = '{
      '{1'b1, 1'b1, 1'b0, 1'b1, O_IDLE},
      '{1'b1, 1'b1, 1'b0, 1'b1, O_VIDEO},
      '{1'b1, 1'b1, 1'b1, 1'b1, O_CPU},
      '{1'b1, 1'b1, 1'b1, 1'b1, O_VIDEO},
      '{1'b1, 1'b1, 1'b1, 1'b0, O_CPU},
      '{1'b1, 1'b1, 1'b0, 1'b1, O_VIDEO},
      '{1'b0, 1'b1, 1'b0, 1'b1, O_IDLE},
      '{1'b0, 1'b1, 1'b0, 1'b1, O_SOUND},
      '{1'b0, 1'b1, 1'b1, 1'b1, O_CPU},
      '{1'b0, 1'b1, 1'b0, 1'b1, O_IDLE},
      '{1'b0, 1'b1, 1'b1, 1'b0, O_CPU},
      '{1'b0, 1'b1, 1'b1, 1'b1, O_CPU},
      '{1'b1, 1'b1, 1'b0, 1'b1, O_IDLE},
      '{1'b1, 1'b1, 1'b0, 1'b1, O_VIDEO},
      '{1'b0, 1'b1, 1'b0, 1'b1, O_IDLE},
      '{1'b0, 1'b1, 1'b0, 1'b1, O_SOUND},
      '{1'b0, 1'b0, 1'b0, 1'b1, O_IDLE},
      '{1'b0, 1'b0, 1'b1, 1'b1, O_CPU},
      '{1'b1, 1'b0, 1'b0, 1'b1, O_IDLE},
      '{1'b1, 1'b0, 1'b1, 1'b0, O_CPU},
      '{1'b1, 1'b1, 1'b0, 1'b1, O_IDLE}
    };

    // Slot table: row s feeds the decision for slot s+1; slot 0 after reset is idle
    _hblank = 1'b1; _vblank = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b1;
    do_reset();
    e.own = O_IDLE; e.rd = 1'b1;
    sb.push_back(e);
    cur = e;
    for (int s = 0; s <= NROWS; s++) begin
      for (int ph = 0; ph < 8; ph++) begin
        if (ph == 0) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty slot=%0d got=empty want=entry", s);
          end else begin
            cur = sb.pop_front();
          end
        end
        check($sformatf("tbl_s%0d_p%0d", s, ph), 32'(outv()), 32'(expv(cur.own, cur.rd, ph)));
        if (cur.own == O_CPU && ph == 6) cpu_req = 1'b0;
        if (ph == 7 && s < NROWS) begin
          _hblank = rows[s].hb; _vblank = rows[s].vb;
          cpu_req = rows[s].req; cpu_rw = rows[s].rd;
          e.own = rows[s].own; e.rd = rows[s].rd;
          sb.push_back(e);
        end
        next();
      end
    end

    // cpu_req held from reset: dtack timing, release, re-grant on next odd slot
    _hblank = 1'b1; _vblank = 1'b1; cpu_req = 1'b1; cpu_rw = 1'b1;
    do_reset();
    run_to(8);  check("a_grant_cpu", 32'(cpuBusControl), 32'd1);
    run_to(13); check("a_dtack_p5", 32'(cpu_dtack), 32'd0);
    run_to(14); check("a_dtack_p6", 32'(cpu_dtack), 32'd1);
    run_to(17); check("a_dtack_held", 32'(cpu_dtack), 32'd1);
    check("a_video_slot2", 32'(loadPixels), 32'd1);
    run_to(20); check("a_dtack_c20", 32'(cpu_dtack), 32'd1);
    cpu_req = 1'b0;
    run_to(21); check("a_dtack_c21", 32'(cpu_dtack), 32'd0);
    run_to(22); cpu_req = 1'b1;
    run_to(24); check("a_regrant", 32'({cpuBusControl, videoBusControl}), 32'b10);
    run_to(29); check("a2_dtack_p5", 32'(cpu_dtack), 32'd0);
    run_to(30); check("a2_dtack_p6", 32'(cpu_dtack), 32'd1);
    #1 _systemReset = 1'b0;
    #1 check("a_reset_dtack_drop", 32'(outv()), 32'd0);

    // Reset at phase 4 of a CPU write slot, then a clean first slot after release
    cpu_req = 1'b1; cpu_rw = 1'b0;
    do_reset();
    run_to(10); check("c_we_p2", 32'({ram_we, ram_oe}), 32'b10);
    run_to(12); check("c_we_p4", 32'({cpuBusControl, ram_we}), 32'b11);
    #1 _systemReset = 1'b0;
    #1 check("c_abort_outputs", 32'(outv()), 32'd0);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      run_to(c);
      check($sformatf("c_idle_c%0d", c), 32'(outv()), 32'd0);
    end
    run_to(8);  check("c_first_slot", 32'({cpuBusControl, cpu_dtack, ram_we}), 32'b100);
    run_to(10); check("c_first_we", 32'(ram_we), 32'd1);
    run_to(14); check("c_first_dtack", 32'(cpu_dtack), 32'd1);

    // Saturating CPU requests in vblank+hblank: refresh must pre-empt one CPU slot
    _hblank = 1'b0; _vblank = 1'b0; cpu_req = 1'b1; cpu_rw = 1'b1;
    do_reset();
    ref_slot = -1; nref = 0; ncpu = 0; after_ref_cpu = 1'b0;
    for (int s = 0; s < 76; s++) begin
      for (int ph = 0; ph < 8; ph++) begin
        if (ph == 3 && s > 0) begin
          if (refresh) begin
            nref++;
            if (ref_slot < 0) ref_slot = s;
          end
          if (cpuBusControl) ncpu++;
          if (ref_slot >= 0 && s == ref_slot + 1) after_ref_cpu = cpuBusControl;
        end
        if (ph == 6 && cpuBusControl) cpu_req = 1'b0;
        if (ph == 6 && refresh) check("b_ref_no_dtack", 32'({cpu_dtack, ram_oe, ram_we}), 32'd0);
        if (ph == 7 && refresh) check("b_ref_cycle_ready", 32'(cycleReady), 32'd1);
        if (ph == 7) cpu_req = 1'b1;
        next();
      end
    end
    check("b_ref_count", 32'(nref), 32'd1);
    check("b_ref_window", 32'(ref_slot >= 64 && ref_slot <= 70), 32'd1);
    check("b_cpu_slots", 32'(ncpu), 32'd74);
    check("b_cpu_after_ref", 32'(after_ref_cpu), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
